rr_decode_arbiter: RTL and testbench

//   Round-robin arbiter sharing one resource between 2**IDX_W requesters.

---
 rtl/rr_decode_arbiter_if.sv | 24 ++
 rtl/rr_decode_arbiter.sv | 100 ++++++++++
 tb/tb_rr_decode_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_decode_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
interface rr_decode_arbiter_if #(
    parameter int IDX_W = 3
);
    localparam int N = 1 << IDX_W;

    logic             ena;
    logic [N-1:0]     req;
    logic             done;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic             timeout;

    modport master (
        output ena, req, done,
        input  gnt, gnt_idx, gnt_vld, timeout
    );

    modport slave (
        input  ena, req, done,
        output gnt, gnt_idx, gnt_vld, timeout
    );
endinterface

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter with hold timeout, one dead cycle between grants
// and a registered one-hot grant bus.
module rr_decode_arbiter #(
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 15
) (
    input logic                clk,
    input logic                rst,
    rr_decode_arbiter_if.slave bus
);
    localparam int N  = 1 << IDX_W;
    localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] cand;
    logic [CW-1:0]    cnt;
    logic [N-1:0]     gnt_r;
    logic [IDX_W-1:0] idx_r;
    logic             vld_r;
    logic             to_r;
    logic             start;
    logic             hold_end;

    assign start    = bus.ena && (|bus.req);
    assign hold_end = (MAX_HOLD != 0) && (cnt == LAST);

    // Scan downward so the nearest set bit after ptr is the last to win.
    always_comb begin
        win  = ptr;
        cand = '0;
        for (int k = N; k >= 1; k--) begin
            cand = ptr + IDX_W'(k);
            if (bus.req[cand]) win = cand;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '1;
            cnt   <= '0;
            gnt_r <= '0;
            idx_r <= '0;
            vld_r <= 1'b0;
            to_r  <= 1'b0;
        end else begin
            to_r <= 1'b0;
            unique case (state)
                IDLE, GAP: begin
                    if (start) begin
                        state <= GRANT;
                        ptr   <= win;
                        idx_r <= win;
                        gnt_r <= N'(1) << win;
                        vld_r <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    cnt <= cnt + CW'(1);
                    if (!bus.ena) begin
                        state <= IDLE;
                        gnt_r <= '0;
                        vld_r <= 1'b0;
                    end else if (bus.done || !bus.req[idx_r]) begin
                        state <= GAP;
                        gnt_r <= '0;
                        vld_r <= 1'b0;
                    end else if (hold_end) begin
                        state <= GAP;
                        gnt_r <= '0;
                        vld_r <= 1'b0;
                        to_r  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt_r <= '0;
                    vld_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt     = gnt_r;
    assign bus.gnt_idx = idx_r;
    assign bus.gnt_vld = vld_r;
    assign bus.timeout = to_r;
endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Randomized and directed bench for rr_decode_arbiter against a
// behavioural owner/priority model.
module tb_rr_decode_arbiter;
    localparam int IDX_W    = 3;
    localparam int N        = 8;
    localparam int MAX_HOLD = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_pass = 0;
    int n_total = 0;

    rr_decode_arbiter_if #(.IDX_W(IDX_W)) bus ();

    rr_decode_arbiter #(
        .IDX_W   (IDX_W),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Model: current owner (-1 none), cycles it has shown its grant so far.
    int m_own;
    int m_ptr;
    int m_hold;
    int m_idx;
    bit m_to;

    function automatic void model_reset();
        m_own  = -1;
        m_ptr  = N - 1;
        m_hold = 0;
        m_idx  = 0;
        m_to   = 1'b0;
    endfunction

    function automatic logic [12:0] exp_out();
        logic [7:0] g;
        g = '0;
        if (m_own >= 0) g[m_own] = 1'b1;
        return {g, 3'(m_idx), (m_own >= 0), m_to};
    endfunction

    function automatic logic [12:0] act_out();
        return {bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.timeout};
    endfunction

    task automatic tick();
        int c;
        bit found;
        @(posedge clk);
        m_to = 1'b0;
        if (m_own >= 0) begin
            if (!bus.ena) m_own = -1;
            else if (bus.done || !bus.req[m_own]) m_own = -1;
            else if (MAX_HOLD != 0 && m_hold == MAX_HOLD) begin
                m_own = -1;
                m_to  = 1'b1;
            end else m_hold++;
        end else if (bus.ena && bus.req != 0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                c = (m_ptr + k) % N;
                if (!found && bus.req[c]) begin
                    found = 1'b1;
                    m_own = c;
                end
            end
            m_ptr  = m_own;
            m_idx  = m_own;
            m_hold = 1;
        end
        #1;
    endtask

    task automatic do_reset();
        bus.ena  = 1'b0;
        bus.req  = '0;
        bus.done = 1'b0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_total++;
        if (bus.gnt !== 8'h00)
            $display("FAIL reset_gnt got %h want 00", bus.gnt);
        else n_pass++;
        n_total++;
        if (bus.gnt_idx !== 3'd0)
            $display("FAIL reset_idx got %0d want 0", bus.gnt_idx);
        else n_pass++;
        n_total++;
        if (bus.gnt_vld !== 1'b0)
            $display("FAIL reset_vld got %b want 0", bus.gnt_vld);
        else n_pass++;
        n_total++;
        if (bus.timeout !== 1'b0)
            $display("FAIL reset_timeout got %b want 0", bus.timeout);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [7:0] want [3] = '{8'h01, 8'h00, 8'h00};
        bus.ena = 1'b1;
        bus.req = 8'h01;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (act_out() !== exp_out() || bus.gnt !== want[i])
                $display("FAIL basic[%0d] got %h want %h", i, act_out(),
                         exp_out());
            else n_pass++;
            bus.done = (i == 0);
            if (i == 1) bus.req = 8'h00;
        end
        bus.done = 1'b0;
    endtask

    task automatic test_rotation();
        logic [7:0] order[$];
        logic prev_vld = 1'b0;
        do_reset();
        bus.ena = 1'b1;
        bus.req = 8'hFF;
        for (int i = 0; i < 30; i++) begin
            bus.done = (i % 3 == 2);
            tick();
            n_total++;
            if (act_out() !== exp_out())
                $display("FAIL rotation[%0d] got %h want %h", i, act_out(),
                         exp_out());
            else n_pass++;
            if (bus.gnt_vld && !prev_vld) order.push_back(bus.gnt);
            prev_vld = bus.gnt_vld;
        end
        bus.done = 1'b0;
        n_total++;
        if (order.size() < 9)
            $display("FAIL rotation_count got %0d want 9", order.size());
        else begin
            n_pass++;
            for (int j = 0; j < 9; j++) begin
                n_total++;
                if (order[j] !== 8'(1 << (j % N)))
                    $display("FAIL rotation_order[%0d] got %h want %h", j,
                             order[j], 8'(1 << (j % N)));
                else n_pass++;
            end
        end
    endtask

    task automatic test_timeout();
        int run = 0;
        int tos = 0;
        int first_run = -1;
        do_reset();
        bus.ena = 1'b1;
        bus.req = 8'h10;
        for (int i = 0; i < 17; i++) begin
            tick();
            n_total++;
            if (act_out() !== exp_out())
                $display("FAIL timeout_seq[%0d] got %h want %h", i, act_out(),
                         exp_out());
            else n_pass++;
            if (bus.timeout) begin
                tos++;
                if (first_run < 0) first_run = run;
            end
            if (bus.gnt == 8'h10) run++;
        end
        n_total++;
        if (first_run !== 15)
            $display("FAIL timeout_len got %0d want 15", first_run);
        else n_pass++;
        n_total++;
        if (tos !== 1)
            $display("FAIL timeout_pulses got %0d want 1", tos);
        else n_pass++;
        n_total++;
        if (bus.gnt !== 8'h10 || bus.gnt_idx !== 3'd4)
            $display("FAIL timeout_regrant got %h/%0d want 10/4", bus.gnt,
                     bus.gnt_idx);
        else n_pass++;
    endtask

    task automatic test_done_at_limit();
        do_reset();
        bus.ena = 1'b1;
        bus.req = 8'h04;
        repeat (15) tick();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        n_total++;
        if (bus.timeout !== 1'b0 || bus.gnt !== 8'h00)
            $display("FAIL done_limit got to=%b gnt=%h want to=0 gnt=00",
                     bus.timeout, bus.gnt);
        else n_pass++;
        n_total++;
        if (act_out() !== exp_out())
            $display("FAIL done_limit_model got %h want %h", act_out(),
                     exp_out());
        else n_pass++;
    endtask

    task automatic test_ena_drop();
        do_reset();
        bus.ena = 1'b1;
        bus.req = 8'h20;
        repeat (3) tick();
        bus.ena = 1'b0;
        tick();
        n_total++;
        if (bus.gnt !== 8'h00 || bus.timeout !== 1'b0)
            $display("FAIL ena_drop got gnt=%h to=%b want 00/0", bus.gnt,
                     bus.timeout);
        else n_pass++;
        bus.ena = 1'b1;
        bus.req = 8'h21;
        tick();
        n_total++;
        if (bus.gnt !== 8'h01 || bus.gnt_idx !== 3'd0)
            $display("FAIL ena_rotate got %h/%0d want 01/0", bus.gnt,
                     bus.gnt_idx);
        else n_pass++;
        bus.req = 8'h00;
        tick();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        bus.ena = 1'b1;
        bus.req = 8'h08;
        repeat (2) tick();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_total++;
        if (bus.gnt !== 8'h00 || bus.gnt_vld !== 1'b0)
            $display("FAIL async_reset got %h/%b want 00/0", bus.gnt,
                     bus.gnt_vld);
        else n_pass++;
        bus.req = 8'h81;
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_total++;
        if (bus.gnt !== 8'h01 || bus.gnt_idx !== 3'd0)
            $display("FAIL reset_priority got %h/%0d want 01/0", bus.gnt,
                     bus.gnt_idx);
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bus.req  = 8'($urandom) & 8'($urandom);
            bus.done = ($urandom % 5 == 0);
            bus.ena  = ($urandom % 16 != 0);
            tick();
            n_total++;
            if (act_out() !== exp_out() || !$onehot0(bus.gnt))
                $display("FAIL random[%0d] got %h want %h", i, act_out(),
                         exp_out());
            else n_pass++;
        end
        bus.ena  = 1'b0;
        bus.done = 1'b0;
        bus.req  = '0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_rotation();
        test_timeout();
        test_done_at_limit();
        test_ena_drop();
        test_reset_mid_grant();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
